// File: rtl/gpioemu_driver.sv
// rtl/gpioemu_driver.sv - bus initiator that runs one multiply/popcount job on the gpioemu peripheral
//
// Parameters: POLL_GAP   idle cycles between status polls (0..255)
//             POLL_LIMIT status polls allowed before giving up (1..65535)
// Ports:      clk, reset           clock, synchronous active-high reset
//             cmd_valid/cmd_ready  command handshake, cmd_a/cmd_b operands
//             rsp_valid/rsp_ready  response handshake, rsp_product/rsp_ones/rsp_timeout payload
//             op_count             completed (non-timeout) commands
//             saddress/swr/srd     peripheral bus address and strobes
//             sdata_out/sdata_in   peripheral write/read data

module gpioemu_driver #(
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a,
  input  logic [23:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_product,
  output logic [23:0] rsp_ones,
  output logic        rsp_timeout,
  output logic [15:0] op_count,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam logic [15:0] ADDR_A      = 16'h037F;
  localparam logic [15:0] ADDR_B      = 16'h0388;
  localparam logic [15:0] ADDR_STATUS = 16'h03A0;
  localparam logic [15:0] ADDR_RESULT = 16'h0390;
  localparam logic [15:0] ADDR_ONES   = 16'h0398;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_STROBE = 2'd1;
  localparam logic [1:0] PH_HOLD   = 2'd2;

  localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_POLL, S_GAP, S_RD_RES, S_RD_ONES, S_RESP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_phase, w_phase_nxt;
  logic [23:0] r_a, r_b;
  logic [15:0] r_poll_cnt;
  logic [7:0]  r_gap_cnt;

  logic w_access;
  logic w_access_end;
  logic w_accept;
  logic w_poll_done;
  logic w_poll_end;
  logic w_last_poll;

  // Every state except IDLE, GAP and RESP is a 3-cycle bus access sequenced by r_phase.
  assign w_access     = (r_state == S_WR_A) || (r_state == S_WR_B) || (r_state == S_WR_GO) ||
                        (r_state == S_POLL) || (r_state == S_RD_RES) || (r_state == S_RD_ONES);
  assign w_access_end = w_access && (r_phase == PH_HOLD);
  assign w_accept     = (r_state == S_IDLE) && cmd_valid;
  assign w_poll_end   = (r_state == S_POLL) && (r_phase == PH_HOLD);
  assign w_poll_done  = (sdata_in[1:0] == 2'b11);
  assign w_last_poll  = (r_poll_cnt == POLL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    saddress    = 16'h0;
    sdata_out   = 32'h0;
    swr         = 1'b0;
    srd         = 1'b0;

    if (w_access) begin
      w_phase_nxt = w_access_end ? PH_SETUP : r_phase + 2'd1;
    end

    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_WR_A;
      end
      S_WR_A: begin
        saddress  = ADDR_A;
        sdata_out = {8'h0, r_a};
        swr       = (r_phase == PH_STROBE);
        if (w_access_end) w_state_nxt = S_WR_B;
      end
      S_WR_B: begin
        saddress  = ADDR_B;
        sdata_out = {8'h0, r_b};
        swr       = (r_phase == PH_STROBE);
        if (w_access_end) w_state_nxt = S_WR_GO;
      end
      S_WR_GO: begin
        saddress = ADDR_STATUS;
        swr      = (r_phase == PH_STROBE);
        if (w_access_end) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        saddress = ADDR_STATUS;
        srd      = (r_phase == PH_STROBE);
        if (w_access_end) begin
          if (w_poll_done)        w_state_nxt = S_RD_RES;
          else if (w_last_poll)   w_state_nxt = S_RESP;
          else if (POLL_GAP == 0) w_state_nxt = S_POLL;
          else                    w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_POLL;
      end
      S_RD_RES: begin
        saddress = ADDR_RESULT;
        srd      = (r_phase == PH_STROBE);
        if (w_access_end) w_state_nxt = S_RD_ONES;
      end
      S_RD_ONES: begin
        saddress = ADDR_ONES;
        srd      = (r_phase == PH_STROBE);
        if (w_access_end) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = PH_SETUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_SETUP;
      r_a         <= 24'h0;
      r_b         <= 24'h0;
      r_poll_cnt  <= 16'h0;
      r_gap_cnt   <= 8'h0;
      rsp_product <= 32'h0;
      rsp_ones    <= 24'h0;
      rsp_timeout <= 1'b0;
      op_count    <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;

      // Clearing the payload at acceptance leaves zeros in place for a timeout response.
      if (w_accept) begin
        r_a         <= cmd_a;
        r_b         <= cmd_b;
        r_poll_cnt  <= 16'h0;
        rsp_product <= 32'h0;
        rsp_ones    <= 24'h0;
        rsp_timeout <= 1'b0;
      end

      if (w_poll_end) begin
        r_poll_cnt <= r_poll_cnt + 16'd1;
        if (!w_poll_done && w_last_poll) rsp_timeout <= 1'b1;
      end

      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 8'd1 : 8'h0;

      if ((r_state == S_RD_RES) && w_access_end)  rsp_product <= sdata_in;
      if ((r_state == S_RD_ONES) && w_access_end) rsp_ones    <= sdata_in[23:0];

      if ((r_state == S_RESP) && rsp_ready && !rsp_timeout) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: doc/gpioemu_driver.md
GPIOEMU_DRIVER -- requirements
Module: gpioemu_driver

Interface
REQ-001 Parameter POLL_GAP, default 4: idle clk cycles between consecutive status polls, range 0..255.
REQ-002 Parameter POLL_LIMIT, default 64: maximum status polls per command before timeout, range 1..65535.
REQ-003 clk  in  1: single clock; all logic on rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 cmd_valid  in  1: command request.
REQ-006 cmd_ready  out  1: driver can accept a command.
REQ-007 cmd_a  in  24: first multiplicand.
REQ-008 cmd_b  in  24: second multiplicand.
REQ-009 rsp_valid  out  1: response available.
REQ-010 rsp_ready  in  1: response consumer ready.
REQ-011 rsp_product  out  32: low 32 bits of product read back from the peripheral.
REQ-012 rsp_ones  out  24: popcount read back from the peripheral.
REQ-013 rsp_timeout  out  1: command aborted, no done status seen.
REQ-014 op_count  out  16: completed non-timeout commands, wraps 0xFFFF->0.
REQ-015 saddress  out  16: peripheral bus address.
REQ-016 swr  out  1: write strobe; peripheral acts on rising edge.
REQ-017 srd  out  1: read strobe; peripheral acts on rising edge.
REQ-018 sdata_out  out  32: write data to peripheral.
REQ-019 sdata_in  in  32: read data from peripheral.

Function
REQ-020 The driver SHALL be the bus initiator for the gpioemu register map: 0x037F operand A, 0x0388 operand B, 0x03A0 start/status, 0x0390 result, 0x0398 ones count.
REQ-021 Every bus access SHALL take exactly 3 cycles: SETUP (address/data driven, strobes 0), STROBE (one strobe 1), HOLD (strobes 0, address/data unchanged).
REQ-022 saddress and sdata_out SHALL be stable from SETUP through HOLD; swr and srd SHALL never be 1 together.
REQ-023 Read data SHALL be sampled from sdata_in at the HOLD cycle's closing edge.
REQ-024 Outside accesses saddress, sdata_out, swr and srd SHALL be 0.
REQ-025 cmd_ready SHALL be 1 only in IDLE; acceptance is cmd_valid&cmd_ready on a rising edge; cmd_a/cmd_b are captured at that edge.
REQ-026 States: IDLE -> WR_A -> WR_B -> WR_GO -> POLL -> (GAP -> POLL)* -> RD_RES -> RD_ONES -> RESP -> IDLE.
REQ-027 WR_A writes {8'h0,cmd_a} to 0x037F; WR_B writes {8'h0,cmd_b} to 0x0388; WR_GO writes 0 to 0x03A0.
REQ-028 POLL reads 0x03A0; status = sdata_in[1:0]; 2'b11 -> RD_RES; otherwise GAP for POLL_GAP cycles, then POLL again.
REQ-029 After POLL_LIMIT polls without 2'b11, the driver SHALL skip both reads and enter RESP with rsp_timeout=1, rsp_product=0, rsp_ones=0.
REQ-030 RD_RES captures sdata_in into rsp_product; RD_ONES captures sdata_in[23:0] into rsp_ones.
REQ-031 RESP holds rsp_valid=1 with all rsp_* stable until rsp_valid&rsp_ready; the handshake edge returns to IDLE.
REQ-032 op_count SHALL increment by 1 on the RESP handshake edge only when rsp_timeout=0.
REQ-033 Latency: if the first poll returns 2'b11, rsp_valid SHALL rise 18 cycles after the acceptance edge; each extra poll adds POLL_GAP+3 cycles.
REQ-034 A new command SHALL NOT be accepted in the RESP handshake cycle; earliest acceptance is the following edge.

Reset
REQ-035 On reset=1 at a rising edge, from any state including mid-strobe: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_product=0, rsp_ones=0, rsp_timeout=0, op_count=0, saddress=0, sdata_out=0, swr=0, srd=0, poll counters=0.
REQ-036 A command in flight at reset SHALL be discarded with no response.

Verification
REQ-037 cmd_a=3, cmd_b=5, model done on 2nd poll -> writes 0x037F=3, 0x0388=5, 0x03A0=0; two 0x03A0 reads; reads 0x0390, 0x0398; rsp_product=15, rsp_ones=4, rsp_timeout=0, op_count=1, rsp_valid at acceptance+25 (POLL_GAP=4).
REQ-038 cmd_a=cmd_b=0xFFFFFF -> rsp_product=0xFE000001, rsp_ones=8, rsp_timeout=0.
REQ-039 POLL_LIMIT=4, model status stuck at 2'b01 -> exactly 4 polls, no 0x0390/0x0398 reads, rsp_timeout=1, rsp_product=0, op_count unchanged.
REQ-040 rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0, no strobes; rsp_ready=1 -> IDLE next cycle.
REQ-041 reset=1 during a POLL STROBE cycle -> next edge: srd=0, saddress=0, cmd_ready=1, rsp_valid=0, op_count=0; later command runs normally.
REQ-042 Checker on all runs: every access is 3 cycles, address/data stable through HOLD, swr&srd never 1 together.
